// File: rtl/fir_delay_timer.sv
// FIR timing generator: start-up counter, end-of-window strobe, and the strobe delayed by DSP58 latency.
// Build option DSP_FIRST_PULSE_MASK_EN suppresses the first delayed pulse after reset (accumulator not primed).
module fir_delay_timer #(
  parameter int delay1        = 4,
  parameter int filter_length = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [5:0] starting_delay,
  output logic       filter_delay,
  output logic       dsp58_delay
);

  localparam int CW = (filter_length > 1) ? $clog2(filter_length) : 1;
  localparam logic [CW-1:0] LAST = CW'(filter_length - 1);

  generate
    if (filter_length < 2 || delay1 < 0 || delay1 > 63) begin : g_bad_params
      $fatal(1, "fir_delay_timer: illegal parameters filter_length=%0d delay1=%0d",
             filter_length, delay1);
    end
  endgenerate

  logic [CW-1:0] wcnt;
  logic          dsp_raw;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starting_delay <= '0;
      wcnt           <= '0;
    end else begin
      if (starting_delay != 6'd63)
        starting_delay <= starting_delay + 6'd1;
      wcnt <= (wcnt == LAST) ? '0 : wcnt + 1'b1;
    end
  end

  assign filter_delay = (wcnt == LAST);

  // One bit per pipeline stage so overlapping windows never merge.
  generate
    if (delay1 == 0) begin : g_nodelay
      assign dsp_raw = filter_delay;
    end else if (delay1 == 1) begin : g_delay1
      logic sr;
      always_ff @(posedge clk) begin
        if (!rst_n) sr <= 1'b0;
        else        sr <= filter_delay;
      end
      assign dsp_raw = sr;
    end else begin : g_delayn
      logic [delay1-1:0] sr;
      always_ff @(posedge clk) begin
        if (!rst_n) sr <= '0;
        else        sr <= {sr[delay1-2:0], filter_delay};
      end
      assign dsp_raw = sr[delay1-1];
    end
  endgenerate

`ifdef DSP_FIRST_PULSE_MASK_EN
  logic primed;

  always_ff @(posedge clk) begin
    if (!rst_n)       primed <= 1'b0;
    else if (dsp_raw) primed <= 1'b1;
  end

  assign dsp58_delay = dsp_raw & primed;
`else
  assign dsp58_delay = dsp_raw;
`endif

endmodule

// File: tb/tb_fir_delay_timer.sv
// Directed bench for fir_delay_timer: default, delay1=0 and delay1=20 instances share clock and reset.
module tb_fir_delay_timer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] sd_a, sd_b, sd_c;
  logic       fd_a, fd_b, fd_c;
  logic       dsp_a, dsp_b, dsp_c;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fir_delay_timer u_dut (
    .clk(clk), .rst_n(rst_n), .starting_delay(sd_a), .filter_delay(fd_a), .dsp58_delay(dsp_a));

  fir_delay_timer #(.delay1(0), .filter_length(16)) u_d0 (
    .clk(clk), .rst_n(rst_n), .starting_delay(sd_b), .filter_delay(fd_b), .dsp58_delay(dsp_b));

  fir_delay_timer #(.delay1(20), .filter_length(16)) u_d20 (
    .clk(clk), .rst_n(rst_n), .starting_delay(sd_c), .filter_delay(fd_c), .dsp58_delay(dsp_c));

  function automatic logic exp_fd(int e);
    return (e % 16) == 15;
  endfunction

  function automatic logic exp_dsp(int e, int lat);
    int first;
    first = 15 + lat;
`ifdef DSP_FIRST_PULSE_MASK_EN
    first = first + 16;
`endif
    return (e >= first) && (((e - first) % 16) == 0);
  endfunction

  function automatic logic [5:0] exp_sd(int e);
    return (e >= 63) ? 6'd63 : 6'(e);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset(int n);
    rst_n = 1'b0;
    repeat (n) tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int r = 1; r <= 5; r++) begin
      tick();
      n_checks++;
      if ({sd_a, fd_a, dsp_a, fd_b, dsp_b, dsp_c} !== 11'd0) begin
        n_fail++;
        $display("FAIL reset_hold edge %0d: sd=%0d fd=%b dsp=%b dsp0=%b dsp20=%b, required all 0",
                 r, sd_a, fd_a, dsp_a, dsp_b, dsp_c);
      end
    end
    rst_n = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      tick();
      n_checks++;
      if (sd_a !== 6'(e)) begin
        n_fail++;
        $display("FAIL count_start edge %0d: starting_delay=%0d required %0d", e, sd_a, e);
      end
    end
  endtask

  task automatic test_period_latency();
    apply_reset(2);
    for (int e = 1; e <= 100; e++) begin
      tick();
      n_checks++;
      if (fd_a !== exp_fd(e)) begin
        n_fail++;
        $display("FAIL period edge %0d: filter_delay=%b required %b", e, fd_a, exp_fd(e));
      end
      n_checks++;
      if (dsp_a !== exp_dsp(e, 4)) begin
        n_fail++;
        $display("FAIL latency4 edge %0d: dsp58_delay=%b required %b", e, dsp_a, exp_dsp(e, 4));
      end
      n_checks++;
      if (dsp_b !== exp_dsp(e, 0)) begin
        n_fail++;
        $display("FAIL latency0 edge %0d: dsp58_delay=%b required %b", e, dsp_b, exp_dsp(e, 0));
      end
      n_checks++;
      if (dsp_c !== exp_dsp(e, 20)) begin
        n_fail++;
        $display("FAIL latency20 edge %0d: dsp58_delay=%b required %b", e, dsp_c, exp_dsp(e, 20));
      end
    end
  endtask

  task automatic test_saturation();
    apply_reset(1);
    for (int e = 1; e <= 70; e++) begin
      tick();
      n_checks++;
      if (sd_a !== exp_sd(e)) begin
        n_fail++;
        $display("FAIL saturation edge %0d: starting_delay=%0d required %0d", e, sd_a, exp_sd(e));
      end
    end
  endtask

  task automatic test_mid_reset();
    apply_reset(1);
    for (int e = 1; e <= 17; e++) begin
      tick();
      n_checks++;
      if (fd_a !== exp_fd(e)) begin
        n_fail++;
        $display("FAIL mid_pre edge %0d: filter_delay=%b required %b", e, fd_a, exp_fd(e));
      end
    end
    rst_n = 1'b0;
    for (int e = 18; e <= 20; e++) begin
      tick();
      n_checks++;
      if ({sd_a, fd_a, dsp_a} !== 8'd0) begin
        n_fail++;
        $display("FAIL mid_reset edge %0d: sd=%0d fd=%b dsp=%b required all 0", e, sd_a, fd_a, dsp_a);
      end
    end
    rst_n = 1'b1;
    for (int e = 1; e <= 40; e++) begin
      tick();
      n_checks++;
      if (fd_a !== exp_fd(e) || dsp_a !== exp_dsp(e, 4)) begin
        n_fail++;
        $display("FAIL mid_restart edge %0d: fd=%b dsp=%b required fd=%b dsp=%b",
                 e, fd_a, dsp_a, exp_fd(e), exp_dsp(e, 4));
      end
      n_checks++;
      if (sd_a !== exp_sd(e)) begin
        n_fail++;
        $display("FAIL mid_count edge %0d: starting_delay=%0d required %0d", e, sd_a, exp_sd(e));
      end
    end
  endtask

  initial begin
    test_reset();
    test_period_latency();
    test_saturation();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fir_delay_timer.md
Name: fir_delay_timer

Overview:
Timing generator for the DSP58-based FIR controller.
- Produces a start-up qualifier, `starting_delay`.
- Produces a one-cycle end-of-window strobe every `filter_length` clocks, `filter_delay`. The address counter uses it to reset `h_addr` and step the `x` window.
- Produces the same strobe delayed by the DSP58 opmode/pipeline latency, `dsp58_delay`. It marks a valid accumulated output.

Parameters:
- delay1, 4, DSP58 pipeline latency in clocks from `filter_delay` to `dsp58_delay`. Legal range 0..63.
- filter_length, 16, number of taps, which equals the window period in clocks. Legal range 2..64.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, synchronous, active-low.
- starting_delay  output  6  saturating count of clocks since reset release.
- filter_delay  output  1  end-of-window strobe, one cycle high per window.
- dsp58_delay  output  1  `filter_delay` delayed by `delay1` clocks.

Behaviour:
- Reset: every edge with rst_n=0 clears `starting_delay`, the window counter `wcnt` and the delay shift register. Outputs are therefore 0/0/0. Asserting reset mid-operation aborts any in-flight `dsp58_delay` pulse; no stale pulse is emitted after release.
- starting_delay: on each edge with rst_n=1, increments by 1 and saturates at 63 (6-bit, no wrap). Downstream logic treats a value ≥1 as "running".
- wcnt: internal counter, width clog2(filter_length). On each edge with rst_n=1 it increments; when it equals filter_length-1 it wraps to 0.
- filter_delay: combinational, `(wcnt == filter_length-1)`, registered-state derived. It is therefore high for exactly 1 cycle of every `filter_length`. The first assertion comes after `filter_length-1` edges following reset release. For the default of 16, that is the cycle after edge 15, then edges 31, 47, …
- dsp58_delay:
  - delay1=0: equals `filter_delay`.
  - delay1≥1: a `delay1`-stage shift register of `filter_delay`, asserted in the cycle after edge `(filter_length-1)+delay1`. For the defaults that is after edge 19, then every 16 clocks; pulse width is 1 cycle.
  - delay1 ≥ filter_length: overlapping windows are all preserved, one pulse per window with no merging or drops.
- Elaboration checks: filter_length<2 or delay1>63 is a fatal error.

Optional Feature:
Macro DSP_FIRST_PULSE_MASK_EN.
- Defined: an internal flag, cleared by reset, suppresses the first `dsp58_delay` pulse after reset release, because the accumulator is not primed. The flag sets when that first delayed pulse would have fired; subsequent pulses pass normally. `filter_delay` is unaffected.
- Undefined: every delayed pulse is passed, as described in Behaviour.

Test Plan:
- Reset hold: rst_n=0 for 5 edges, then release → `starting_delay` counts 1,2,3… on successive edges; both strobes are 0 while in reset.
- Period (defaults): run 100 edges after release → `filter_delay` is high only in the cycles after edges 15, 31, 47, 63, 79, 95, each 1 cycle wide.
- Latency (defaults): `dsp58_delay` is high only after edges 19, 35, 51, 67, 83, 99. Re-run with delay1=0 → it matches `filter_delay`. Re-run with delay1=20 → first pulse after edge 35.
- Saturation: run 70 edges → `starting_delay` holds 63 from edge 63 onward with no wrap to 0.
- Mid-operation reset: assert rst_n=0 at edge 17 (after a `filter_delay`, before the `dsp58_delay` at 19), release at edge 20 → no `dsp58_delay` pulse appears; the sequence restarts with `filter_delay` at 15 edges after release.
- Macro: with DSP_FIRST_PULSE_MASK_EN defined and defaults → first `dsp58_delay` pulse occurs after edge 35 and not after edge 19; the macro-off build pulses after 19.
